// File: rtl/calc_if.sv
// Handshake bundle between the UART receiver, echo path, command consumer
// and the calculator input parser.
interface calc_if #(
   parameter int OPERAND_W = 16
);
   logic                 rx_valid;
   logic [7:0]           rx_data;
   logic                 rx_break;
   logic                 echo_valid;
   logic [7:0]           echo_data;
   logic                 echo_ready;
   logic [1:0]           field;
   logic [OPERAND_W-1:0] op_a;
   logic [OPERAND_W-1:0] op_b;
   logic [1:0]           op_code;
   logic                 cmd_valid;
   logic                 cmd_ack;
   logic                 err_range;
   logic                 err_overrun;

   modport master (
      output rx_valid, rx_data, rx_break, echo_ready, cmd_ack,
      input  echo_valid, echo_data, field, op_a, op_b, op_code,
      input  cmd_valid, err_range, err_overrun
   );

   modport slave (
      input  rx_valid, rx_data, rx_break, echo_ready, cmd_ack,
      output echo_valid, echo_data, field, op_a, op_b, op_code,
      output cmd_valid, err_range, err_overrun
   );
endinterface

// File: rtl/calc_input_parser.sv
// Collects operand 1, operand 2 and operator from UART bytes, echoes
// accepted characters and holds the finished command until acknowledged.
module calc_input_parser #(
   parameter int OPERAND_W  = 16,
   parameter int MAX_DIGITS = 5
) (
   input logic  clk,
   input logic  reset,
   calc_if.slave bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int PW = OPERAND_W + 4;
   localparam logic [PW-1:0] MAXV = {4'b0, {OPERAND_W{1'b1}}};

   typedef enum logic [1:0] {
      INPUT1 = 2'd0,
      INPUT2 = 2'd1,
      OPER   = 2'd2,
      DONE   = 2'd3
   } field_t;

   field_t               state;
   logic [OPERAND_W-1:0] op_a_q;
   logic [OPERAND_W-1:0] op_b_q;
   logic [1:0]           op_code_q;
   logic [CW-1:0]        count;
   logic                 op_seen;
   logic                 cmd_v;
   logic                 echo_v;
   logic [7:0]           echo_d;
   logic                 err_r;
   logic                 err_o;

   logic [OPERAND_W-1:0] acc;
   logic [PW-1:0]        prod;
   logic                 is_digit;
   logic                 is_del;
   logic                 is_cr;
   logic                 digit_ok;
   logic                 op_hit;
   logic [1:0]           op_enc;
   logic                 clr;
   logic                 echo_busy;

   assign acc       = (state == INPUT2) ? op_b_q : op_a_q;
   assign is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
   assign is_del    = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);
   assign is_cr     = (bus.rx_data == 8'h0D);
   // Computed wide so the overflow check sees the true value
   assign prod      = ({4'b0, acc} * PW'(10))
                    + {{OPERAND_W{1'b0}}, bus.rx_data[3:0]};
   assign digit_ok  = (count < CW'(MAX_DIGITS)) && (prod <= MAXV);
   assign clr       = bus.rx_break || ((state == DONE) && bus.cmd_ack);
   assign echo_busy = echo_v && !bus.echo_ready;

   always_comb begin
      op_hit = 1'b1;
      op_enc = 2'b00;
      unique case (bus.rx_data)
         8'h2B:   op_enc = 2'b00;
         8'h2D:   op_enc = 2'b01;
         8'h2A:   op_enc = 2'b10;
         8'h2F:   op_enc = 2'b11;
         default: op_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INPUT1;
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_code_q <= 2'b00;
         count     <= '0;
         op_seen   <= 1'b0;
         cmd_v     <= 1'b0;
         echo_v    <= 1'b0;
         echo_d    <= 8'h00;
         err_r     <= 1'b0;
         err_o     <= 1'b0;
      end else if (clr) begin
         state   <= INPUT1;
         op_a_q  <= '0;
         op_b_q  <= '0;
         count   <= '0;
         op_seen <= 1'b0;
         cmd_v   <= 1'b0;
         err_r   <= 1'b0;
         err_o   <= 1'b0;
         if (bus.rx_break || bus.echo_ready)
            echo_v <= 1'b0;
      end else begin
         if (echo_v && bus.echo_ready)
            echo_v <= 1'b0;
         if (bus.rx_valid && state != DONE) begin
            if (echo_busy) begin
               err_o <= 1'b1;
            end else begin
               unique case (state)
                  INPUT1, INPUT2: begin
                     if (is_digit) begin
                        if (digit_ok) begin
                           if (state == INPUT1)
                              op_a_q <= prod[OPERAND_W-1:0];
                           else
                              op_b_q <= prod[OPERAND_W-1:0];
                           count  <= count + CW'(1);
                           echo_v <= 1'b1;
                           echo_d <= bus.rx_data;
                        end else begin
                           err_r <= 1'b1;
                        end
                     end else if (is_del) begin
                        if (state == INPUT1)
                           op_a_q <= '0;
                        else
                           op_b_q <= '0;
                        count <= '0;
                     end else if (is_cr && count != '0) begin
                        state <= (state == INPUT1) ? INPUT2 : OPER;
                        count <= '0;
                     end
                  end
                  OPER: begin
                     if (op_hit) begin
                        op_code_q <= op_enc;
                        op_seen   <= 1'b1;
                        echo_v    <= 1'b1;
                        echo_d    <= bus.rx_data;
                     end else if (is_del) begin
                        op_seen <= 1'b0;
                     end else if (is_cr && op_seen) begin
                        state <= DONE;
                        cmd_v <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.field       = state;
   assign bus.op_a        = op_a_q;
   assign bus.op_b        = op_b_q;
   assign bus.op_code     = op_code_q;
   assign bus.cmd_valid   = cmd_v;
   assign bus.echo_valid  = echo_v;
   assign bus.echo_data   = echo_d;
   assign bus.err_range   = err_r;
   assign bus.err_overrun = err_o;
endmodule

// File: tb/tb_calc_input_parser.sv
// Directed and random stimulus for calc_input_parser against a
// behavioural model of the calculator entry rules.
module tb_calc_input_parser;
   logic clk = 1'b0;
   logic reset;

   calc_if #(.OPERAND_W(16)) bus ();

   calc_input_parser #(.OPERAND_W(16), .MAX_DIGITS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int m_field, m_a, m_b, m_op, m_cnt, m_ed;
   bit m_seen, m_cmdv, m_er, m_eo, m_ev;

   byte unsigned got_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("field", int'(bus.field), m_field);
      check("op_a", int'(bus.op_a), m_a);
      check("op_b", int'(bus.op_b), m_b);
      check("op_code", int'(bus.op_code), m_op);
      check("cmd_valid", int'(bus.cmd_valid), int'(m_cmdv));
      check("echo_valid", int'(bus.echo_valid), int'(m_ev));
      check("echo_data", int'(bus.echo_data), m_ed);
      check("err_range", int'(bus.err_range), int'(m_er));
      check("err_overrun", int'(bus.err_overrun), int'(m_eo));
   endtask

   function automatic void m_clear();
      m_field = 0; m_a = 0; m_b = 0; m_cnt = 0;
      m_seen = 0; m_cmdv = 0; m_er = 0; m_eo = 0;
   endfunction

   function automatic int op_index(input int c);
      case (c)
         43: return 0;
         45: return 1;
         42: return 2;
         47: return 3;
         default: return -1;
      endcase
   endfunction

   // Reference: one received byte interpreted against the entry rules
   function automatic void m_byte(input int c);
      int cur, v;
      if (m_field < 2) begin
         cur = (m_field == 0) ? m_a : m_b;
         if (c >= 48 && c <= 57) begin
            v = cur * 10 + (c - 48);
            if (m_cnt < 5 && v <= 65535) begin
               if (m_field == 0) m_a = v; else m_b = v;
               m_cnt++;
               m_ev = 1; m_ed = c;
            end else begin
               m_er = 1;
            end
         end else if (c == 8 || c == 127) begin
            if (m_field == 0) m_a = 0; else m_b = 0;
            m_cnt = 0;
         end else if (c == 13 && m_cnt > 0) begin
            m_field++;
            m_cnt = 0;
         end
      end else if (m_field == 2) begin
         if (op_index(c) >= 0) begin
            m_op = op_index(c); m_seen = 1;
            m_ev = 1; m_ed = c;
         end else if (c == 8 || c == 127) begin
            m_seen = 0;
         end else if (c == 13 && m_seen) begin
            m_field = 3; m_cmdv = 1;
         end
      end
   endfunction

   task automatic step(input bit rv, input int rd, input bit rb,
                       input bit er, input bit ack);
      bit old_ev;
      bus.rx_valid   = rv;
      bus.rx_data    = 8'(rd);
      bus.rx_break   = rb;
      bus.echo_ready = er;
      bus.cmd_ack    = ack;
      if (bus.echo_valid && er) got_q.push_back(bus.echo_data);
      old_ev = m_ev;
      if (old_ev && er) m_ev = 0;
      if (rb) begin
         m_clear(); m_ev = 0;
      end else if (m_field == 3 && ack) begin
         m_clear();
      end else if (rv && m_field != 3) begin
         if (old_ev && !er) m_eo = 1;
         else m_byte(rd);
      end
      @(posedge clk); #1;
      compare_all();
   endtask

   task automatic send(input int c);
      step(1, c, 0, 1, 0);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(int'(s[i]));
   endtask

   task automatic do_reset();
      reset = 1;
      bus.rx_valid = 0; bus.rx_data = 0; bus.rx_break = 0;
      bus.echo_ready = 1; bus.cmd_ack = 0;
      m_clear(); m_op = 0; m_ev = 0; m_ed = 0;
      @(posedge clk); #1;
      reset = 0;
      compare_all();
   endtask

   initial begin
      string exp_echo;
      int r, c;
      byte unsigned pool[16];
      pool = '{8'h30, 8'h31, 8'h35, 8'h36, 8'h39, 8'h37, 8'h0D, 8'h0D,
               8'h08, 8'h7F, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h41, 8'h20};

      do_reset();

      // Basic command
      got_q.delete();
      send_str("12"); send(13); send_str("34"); send(13);
      send_str("+"); send(13);
      step(0, 0, 0, 1, 0);
      check("t1_op_a", int'(bus.op_a), 12);
      check("t1_op_b", int'(bus.op_b), 34);
      check("t1_field", int'(bus.field), 3);
      check("t1_cmd_valid", int'(bus.cmd_valid), 1);
      exp_echo = "1234+";
      check("t1_echo_len", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++)
         check("t1_echo_chr", int'(got_q[i]), int'(exp_echo[i]));
      step(0, 0, 0, 1, 1);
      check("t1_ack_field", int'(bus.field), 0);
      check("t1_ack_cmd", int'(bus.cmd_valid), 0);

      // Digit limit and overflow
      send_str("65535"); send(int'("6"));
      check("t2_max", int'(bus.op_a), 65535);
      check("t2_err", int'(bus.err_range), 1);
      do_reset();
      send_str("65536");
      check("t2_ovf", int'(bus.op_a), 6553);
      check("t2_ovf_err", int'(bus.err_range), 1);
      do_reset();

      // Edit and empty commit
      send(13);
      check("t3_empty_cr", int'(bus.field), 0);
      send_str("9"); send(8); send_str("7"); send(13);
      check("t3_edit", int'(bus.op_a), 7);
      send_str("1"); send(13);
      send_str("*"); send_str("/"); send(13);
      check("t3_opcode", int'(bus.op_code), 3);
      check("t3_done", int'(bus.field), 3);
      step(0, 0, 0, 1, 1);

      // Overrun
      step(1, int'("1"), 0, 0, 0);
      step(1, int'("2"), 0, 0, 0);
      check("t4_echo", int'(bus.echo_data), int'("1"));
      check("t4_ovr", int'(bus.err_overrun), 1);
      check("t4_op_a", int'(bus.op_a), 1);
      step(0, 0, 0, 1, 0);
      do_reset();

      // Break mid-entry
      send_str("55"); send(13); step(1, int'("3"), 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("t5_field", int'(bus.field), 0);
      check("t5_op_b", int'(bus.op_b), 0);
      check("t5_echo", int'(bus.echo_valid), 0);

      // DONE hold, ack with simultaneous byte
      send_str("2"); send(13); send_str("3"); send(13);
      send_str("-"); send(13);
      send_str("8");
      check("t6_hold_a", int'(bus.op_a), 2);
      step(1, int'("4"), 0, 1, 1);
      check("t6_ack_a", int'(bus.op_a), 0);
      check("t6_ack_field", int'(bus.field), 0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 999));
         if (r < 2) begin
            do_reset();
         end else begin
            c = int'(pool[$urandom_range(0, 15)]);
            step(bit'($urandom_range(0, 1)), c, r < 12,
                 $urandom_range(0, 3) != 0,
                 (m_field == 3) ? $urandom_range(0, 5) == 0
                                : $urandom_range(0, 9) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
